hazard_scoreboard: RTL and testbench

Parametrised load-use and control hazard unit for the 5-stage pipeline. It replaces the single-cycle load-use compare with a per-register countdown scoreboard, so data-memory latency (LOAD_LAT) can grow without changing the compare logic. It also generates the stall and flush controls for the PC, IF/ID and ID/EX registers, and handles jump-register operands that must be resolved in ID. It sits beside the ID stage and is fed from the IF/ID and ID/EX pipeline registers and the EX branch resolver.

---
 rtl/hazard_scoreboard.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use and control hazard unit for the 5-stage pipeline. A 3-bit
//   countdown per architectural register tracks loads still in flight.
//   The unit produces stall/flush controls for PC, IF/ID and ID/EX, and
//   detects jump-register operands that cannot be forwarded into ID.
//
// Parameters
//   REG_AW   register-address width (scoreboard depth 2**REG_AW)
//   LOAD_LAT cycles after a load leaves ID before its data is forwardable (1..7)
//   CNT_W    performance counter width
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   id_rs/id_rt(+_used)       ID source registers and their use flags
//   id_opcode, id_funct       ID decode fields
//   id_is_load, id_rd         ID load flag and destination
//   ex_reg_write, ex_rd       EX write-back info
//   branch_taken              EX branch resolved taken
//   pc_wr_en, if_id_wr_en     write enables (low on stall)
//   if_id_flush, id_ex_flush  flush / bubble controls
//   stall, busy               hazard stall; any scoreboard entry pending
//   stall_cnt, flush_cnt      performance counters
//
// Build option
//   HAZARD_PERF_CNT_EN  when defined, stall_cnt/flush_cnt count; otherwise tied to 0.

module hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  output logic              pc_wr_en,
  output logic              if_id_wr_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              stall,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned DEPTH = 1 << REG_AW;
  localparam logic [2:0]  LAT   = 3'(LOAD_LAT);

  logic [2:0] r_sb [DEPTH];

  logic w_is_jr;
  logic w_is_jump;
  logic w_haz_rs;
  logic w_haz_rt;
  logic w_haz_jr;
  logic w_stall;
  logic w_issue;
  logic w_busy;
  logic w_if_id_flush;

  assign w_is_jr   = (id_opcode == 6'h00) && ((id_funct == 6'h08) || (id_funct == 6'h09));
  assign w_is_jump = w_is_jr || (id_opcode == 6'h02) || (id_opcode == 6'h03);

  assign w_haz_rs = id_rs_used && (id_rs != '0) && (r_sb[id_rs] != '0);
  assign w_haz_rt = id_rt_used && (id_rt != '0) && (r_sb[id_rt] != '0);
  // jr/jalr read rs in ID, so an ALU result still in EX cannot reach it yet.
  assign w_haz_jr = w_is_jr && ex_reg_write && (ex_rd == id_rs) && (id_rs != '0);

  // A taken branch discards the ID instruction, so its hazards are moot.
  assign w_stall = (w_haz_rs || w_haz_rt || w_haz_jr) && !branch_taken;

  assign w_issue = id_is_load && !w_stall && !branch_taken && (id_rd != '0);

  assign w_if_id_flush = branch_taken || (w_is_jump && !w_stall);

  assign stall       = w_stall;
  assign pc_wr_en    = !w_stall;
  assign if_id_wr_en = !w_stall;
  assign id_ex_flush = branch_taken || w_stall;
  assign if_id_flush = w_if_id_flush;

  always_comb begin
    w_busy = 1'b0;
    for (int unsigned r = 1; r < DEPTH; r++) begin
      w_busy = w_busy || (r_sb[r] != '0);
    end
  end
  assign busy = w_busy;

  // Entry 0 is held at zero; a fresh issue overrides the decrement.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        r_sb[r] <= '0;
      end
    end else begin
      r_sb[0] <= '0;
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (w_issue && (id_rd == REG_AW'(r))) begin
          r_sb[r] <= LAT;
        end else if (r_sb[r] != '0) begin
          r_sb[r] <= r_sb[r] - 3'd1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall)       r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_if_id_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: two instances (LOAD_LAT=1 and 3) share
// stimulus; expected output vectors are queued on drive and popped on sample.
// Vector order: {stall, pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, busy}.

module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, id_rd, ex_rd;
  logic       id_rs_used, id_rt_used, id_is_load, ex_reg_write, branch_taken;
  logic [5:0] id_opcode, id_funct;

  logic        pc0, ifw0, iff0, idf0, st0, bz0;
  logic        pc1, ifw1, iff1, idf1, st1, bz1;
  logic [31:0] scnt0, fcnt0, scnt1, fcnt1;

  int compared   = 0;
  int mismatched = 0;

  string      q_tag [$];
  int         q_dut [$];
  logic [5:0] q_exp [$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_is_load(id_is_load), .id_rd(id_rd),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_wr_en(pc0), .if_id_wr_en(ifw0), .if_id_flush(iff0), .id_ex_flush(idf0),
    .stall(st0), .busy(bz0), .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_is_load(id_is_load), .id_rd(id_rd),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .pc_wr_en(pc1), .if_id_wr_en(ifw1), .if_id_flush(iff1), .id_ex_flush(idf1),
    .stall(st1), .busy(bz1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  task automatic idle();
    id_rs = '0; id_rt = '0; id_rd = '0; ex_rd = '0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_is_load = 1'b0;
    ex_reg_write = 1'b0; branch_taken = 1'b0;
    id_opcode = 6'h00; id_funct = 6'h20;
  endtask

  // Push expectation, sample on the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input int dut, input logic [5:0] exp);
    string      t;
    int         d;
    logic [5:0] e;
    logic [5:0] obs;
    q_tag.push_back(tag); q_dut.push_back(dut); q_exp.push_back(exp);
    @(negedge clk);
    t = q_tag.pop_front(); d = q_dut.pop_front(); e = q_exp.pop_front();
    obs = (d == 0) ? {st0, pc0, ifw0, iff0, idf0, bz0} : {st1, pc1, ifw1, iff1, idf1, bz1};
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] e);
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    cyc("reset_idle_lat1", 0, 6'b011000);
    cyc("reset_idle_lat3", 1, 6'b011000);
    do_reset();

    // LOAD_LAT=1: load r5, dependent add on rs, then a jump.
    id_is_load = 1'b1; id_rd = 5'd5;
    cyc("l1_load_r5", 0, 6'b011000);
    idle(); id_rs = 5'd5; id_rs_used = 1'b1;
    cyc("l1_use_stall", 0, 6'b100011);
    cyc("l1_use_release", 0, 6'b011000);
    idle(); id_opcode = 6'h02;
    cyc("l1_jump_flush", 0, 6'b011100);
    idle();
    cyc("l1_idle_after", 0, 6'b011000);
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("stall_cnt", scnt0, 32'd1);
    chk_cnt("flush_cnt", fcnt0, 32'd1);
`else
    chk_cnt("stall_cnt_tied", scnt0, 32'd0);
    chk_cnt("flush_cnt_tied", fcnt0, 32'd0);
`endif
    do_reset();

    // LOAD_LAT=3: load r7, dependent via rt stalls 3 cycles.
    id_is_load = 1'b1; id_rd = 5'd7;
    cyc("l3_load_r7", 1, 6'b011000);
    idle(); id_rt = 5'd7; id_rt_used = 1'b1;
    cyc("l3_stall_1", 1, 6'b100011);
    cyc("l3_stall_2", 1, 6'b100011);
    cyc("l3_stall_3", 1, 6'b100011);
    cyc("l3_release", 1, 6'b011000);
    idle(); id_is_load = 1'b1; id_rd = 5'd7;
    cyc("l3_load_r7_again", 1, 6'b011000);
    idle(); id_rt = 5'd8; id_rt_used = 1'b1;
    cyc("l3_r8_no_stall", 1, 6'b011001);
    do_reset();

    // jr hazard against an ALU writer in EX, then plain jumps.
    id_opcode = 6'h00; id_funct = 6'h08; id_rs = 5'd9; id_rs_used = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd9;
    cyc("jr_stall", 0, 6'b100010);
    ex_reg_write = 1'b0; ex_rd = '0;
    cyc("jr_flush", 0, 6'b011100);
    idle(); id_opcode = 6'h03;
    cyc("jal_flush", 0, 6'b011100);
    idle(); id_funct = 6'h09; id_rs = 5'd9; id_rs_used = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd9;
    cyc("jalr_stall", 0, 6'b100010);
    ex_rd = 5'd10;
    cyc("jalr_other_rd", 0, 6'b011100);
    do_reset();

    // Branch suppresses issue; branch beats a stall; r0 never tracked.
    id_is_load = 1'b1; id_rd = 5'd4; branch_taken = 1'b1;
    cyc("br_load_r4", 0, 6'b011110);
    idle(); id_rs = 5'd4; id_rs_used = 1'b1;
    cyc("br_r4_clear", 0, 6'b011000);
    idle(); id_is_load = 1'b1; id_rd = 5'd6;
    cyc("load_r6", 0, 6'b011000);
    idle(); id_rs = 5'd6; id_rs_used = 1'b1; branch_taken = 1'b1;
    cyc("br_beats_stall", 0, 6'b011111);
    idle(); id_is_load = 1'b1; id_rd = 5'd0;
    cyc("load_r0", 0, 6'b011000);
    idle();
    cyc("r0_not_busy", 0, 6'b011000);
    do_reset();

    // Reset mid-countdown discards the pending load.
    id_is_load = 1'b1; id_rd = 5'd3;
    cyc("rst_load_r3", 1, 6'b011000);
    idle();
    cyc("rst_pending", 1, 6'b011001);
    reset_n = 1'b0;
    cyc("rst_asserted", 1, 6'b011001);
    reset_n = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1;
    cyc("rst_r3_no_stall", 1, 6'b011000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
